// File: rtl/sdram_slot_arbiter.sv
// Two-port (CPU/PPU) arbiter for the 8-phase SDRAM slot controller: owns the slot phase and sync,
// grants at most one request per slot, holds the command for the slot and returns read data with an ack.
module sdram_slot_arbiter #(
  parameter int unsigned RR_MODE     = 1,
  parameter int unsigned REFRESH_MAX = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_ds,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic        ppu_req,
  input  logic        ppu_we,
  input  logic [19:0] ppu_addr,
  input  logic [15:0] ppu_din,
  input  logic [1:0]  ppu_ds,
  output logic        ppu_ack,
  output logic [15:0] ppu_dout,
  output logic        sd_sync,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [19:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  input  logic [15:0] sd_dout
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_PPU = 1'b1
  } owner_t;

  localparam logic [7:0] BUSY_LIMIT = 8'(REFRESH_MAX);

  logic [2:0]  phase_q, phase_d;
  logic        sync_q, sync_d;
  logic        oe_q, oe_d, we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic [1:0]  ds_q, ds_d;
  logic [7:0]  busy_q, busy_d;
  owner_t      last_q, last_d;
  logic        infl_q, infl_d;
  owner_t      infl_own_q, infl_own_d;
  logic        infl_we_q, infl_we_d;
  logic        cpu_ack_q, cpu_ack_d, ppu_ack_q, ppu_ack_d;
  logic [15:0] cpu_dout_q, cpu_dout_d, ppu_dout_q, ppu_dout_d;

  logic   slot_end, force_idle, cpu_elig, ppu_elig;
  owner_t winner;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q    <= '0;
      sync_q     <= 1'b0;
      oe_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      ds_q       <= '0;
      busy_q     <= '0;
      last_q     <= OWN_PPU;
      infl_q     <= 1'b0;
      infl_own_q <= OWN_CPU;
      infl_we_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      ppu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      ppu_dout_q <= '0;
    end else begin
      phase_q    <= phase_d;
      sync_q     <= sync_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ds_q       <= ds_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      infl_q     <= infl_d;
      infl_own_q <= infl_own_d;
      infl_we_q  <= infl_we_d;
      cpu_ack_q  <= cpu_ack_d;
      ppu_ack_q  <= ppu_ack_d;
      cpu_dout_q <= cpu_dout_d;
      ppu_dout_q <= ppu_dout_d;
    end
  end

  always_comb begin
    phase_d    = phase_q + 3'd1;
    sync_d     = ~phase_d[2];
    oe_d       = oe_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    ds_d       = ds_q;
    busy_d     = busy_q;
    last_d     = last_q;
    infl_d     = infl_q;
    infl_own_d = infl_own_q;
    infl_we_d  = infl_we_q;
    cpu_ack_d  = 1'b0;
    ppu_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    ppu_dout_d = ppu_dout_q;
    winner     = OWN_CPU;

    slot_end   = (phase_q == 3'd7);
    force_idle = (busy_q == BUSY_LIMIT);
    // The port whose slot finishes at this edge has not seen its ack yet, so its req is stale.
    cpu_elig   = cpu_req && !(infl_q && infl_own_q == OWN_CPU);
    ppu_elig   = ppu_req && !(infl_q && infl_own_q == OWN_PPU);

    if (slot_end) begin
      if (infl_q) begin
        if (infl_own_q == OWN_CPU) begin
          cpu_ack_d = 1'b1;
          if (!infl_we_q) cpu_dout_d = sd_dout;
        end else begin
          ppu_ack_d = 1'b1;
          if (!infl_we_q) ppu_dout_d = sd_dout;
        end
      end

      if (force_idle || !(cpu_elig || ppu_elig)) begin
        oe_d   = 1'b0;
        we_d   = 1'b0;
        busy_d = '0;
        infl_d = 1'b0;
      end else begin
        if (cpu_elig && ppu_elig)
          winner = (RR_MODE != 0 && last_q == OWN_CPU) ? OWN_PPU : OWN_CPU;
        else
          winner = cpu_elig ? OWN_CPU : OWN_PPU;

        we_d       = (winner == OWN_PPU) ? ppu_we   : cpu_we;
        addr_d     = (winner == OWN_PPU) ? ppu_addr : cpu_addr;
        din_d      = (winner == OWN_PPU) ? ppu_din  : cpu_din;
        ds_d       = (winner == OWN_PPU) ? ppu_ds   : cpu_ds;
        oe_d       = ~we_d;
        busy_d     = busy_q + 8'd1;
        last_d     = winner;
        infl_d     = 1'b1;
        infl_own_d = winner;
        infl_we_d  = we_d;
      end
    end
  end

  assign sd_sync  = sync_q;
  assign sd_oe    = oe_q;
  assign sd_we    = we_q;
  assign sd_addr  = addr_q;
  assign sd_din   = din_q;
  assign sd_ds    = ds_q;
  assign cpu_ack  = cpu_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign ppu_ack  = ppu_ack_q;
  assign ppu_dout = ppu_dout_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: slot-level reference model feeds per-port ack queues, a negedge
// monitor checks bus, sync and acks; directed scenarios followed by randomized traffic.
module tb_sdram_slot_arbiter;

  localparam int RR  = 1;
  localparam int REF = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [19:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  logic [1:0]  cpu_ds = '0;
  logic        cpu_ack;
  logic [15:0] cpu_dout;
  logic        ppu_req = 1'b0, ppu_we = 1'b0;
  logic [19:0] ppu_addr = '0;
  logic [15:0] ppu_din = '0;
  logic [1:0]  ppu_ds = '0;
  logic        ppu_ack;
  logic [15:0] ppu_dout;
  logic        sd_sync, sd_oe, sd_we;
  logic [19:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_ds;
  logic [15:0] sd_dout = '0;

  sdram_slot_arbiter #(.RR_MODE(RR), .REFRESH_MAX(REF)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ds(cpu_ds),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_din(ppu_din), .ppu_ds(ppu_ds),
    .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
    .sd_sync(sd_sync), .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
    .sd_ds(sd_ds), .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [15:0] dout;
  } item_t;

  item_t cpu_q[$];
  item_t ppu_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state, advanced once per clock edge.
  int          m_phase = 0;
  bit          m_sync = 0, m_oe = 0, m_we = 0, m_gslot = 1, m_infl = 0;
  int          m_busy = 0, m_last = 1, m_own = 0;
  logic [19:0] m_addr = '0;
  logic [15:0] m_din = '0;
  logic [1:0]  m_ds = '0;
  logic [15:0] m_rd [2] = '{16'h0, 16'h0};
  int unsigned ecount = 0;

  bit rand_en = 0;
  int raise_pct = 0, drop_pct = 0;

  function automatic logic [15:0] mem_data(input logic [19:0] a);
    if (a == 20'h12345) return 16'hBEEF;
    return a[15:0] ^ {a[19:16], a[11:0]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_phase = 0; m_sync = 0; m_oe = 0; m_we = 0; m_gslot = 1;
      m_addr = '0; m_din = '0; m_ds = '0;
      m_busy = 0; m_last = 1; m_infl = 0;
      m_rd[0] = '0; m_rd[1] = '0;
      cpu_q.delete(); ppu_q.delete();
    end else begin
      if (m_phase == 7) begin
        bit c_ok, p_ok, w_we;
        int w;
        item_t it;
        c_ok = cpu_req && !(m_infl && m_own == 0);
        p_ok = ppu_req && !(m_infl && m_own == 1);
        if (m_busy == REF || (!c_ok && !p_ok)) begin
          m_oe = 0; m_we = 0; m_gslot = 0; m_busy = 0; m_infl = 0;
        end else begin
          if (c_ok && p_ok) w = (RR != 0) ? 1 - m_last : 0;
          else w = c_ok ? 0 : 1;
          w_we   = (w == 0) ? cpu_we : ppu_we;
          m_addr = (w == 0) ? cpu_addr : ppu_addr;
          m_din  = (w == 0) ? cpu_din : ppu_din;
          m_ds   = (w == 0) ? cpu_ds : ppu_ds;
          m_we = w_we; m_oe = !w_we; m_gslot = 1;
          m_busy++; m_last = w; m_infl = 1; m_own = w;
          if (!w_we) m_rd[w] = mem_data(m_addr);
          it.due  = ecount + 9;
          it.dout = m_rd[w];
          if (w == 0) cpu_q.push_back(it); else ppu_q.push_back(it);
        end
      end
      m_phase = (m_phase + 1) % 8;
      m_sync  = (m_phase < 4);
    end
    ecount++;
  end

  initial forever begin
    bit exp_c, exp_p;
    @(negedge clk);
    chk("sd_sync", sd_sync, m_sync);
    chk("sd_oe", sd_oe, m_oe);
    chk("sd_we", sd_we, m_we);
    if (m_gslot) begin
      chk("sd_addr", sd_addr, m_addr);
      chk("sd_din", sd_din, m_din);
      chk("sd_ds", sd_ds, m_ds);
    end
    exp_c = (cpu_q.size() > 0) && (cpu_q[0].due == ecount);
    exp_p = (ppu_q.size() > 0) && (ppu_q[0].due == ecount);
    chk("cpu_ack", cpu_ack, exp_c);
    chk("ppu_ack", ppu_ack, exp_p);
    if (exp_c) begin
      if (cpu_ack) chk("cpu_dout", cpu_dout, cpu_q[0].dout);
      void'(cpu_q.pop_front());
    end
    if (exp_p) begin
      if (ppu_ack) chk("ppu_dout", ppu_dout, ppu_q[0].dout);
      void'(ppu_q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    sd_dout = (m_phase == 7) ? mem_data(sd_addr) : 16'($urandom);
    if (cpu_ack) cpu_req = 1'b0;
    if (ppu_ack) ppu_req = 1'b0;
    if (rand_en) begin
      if (!cpu_req && $urandom_range(0, 99) < raise_pct) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom); cpu_addr = 20'($urandom);
        cpu_din = 16'($urandom); cpu_ds = 2'($urandom);
      end else if (cpu_req && $urandom_range(0, 99) < drop_pct) cpu_req = 1'b0;
      if (!ppu_req && $urandom_range(0, 99) < raise_pct) begin
        ppu_req = 1'b1; ppu_we = 1'($urandom); ppu_addr = 20'($urandom);
        ppu_din = 16'($urandom); ppu_ds = 2'($urandom);
      end else if (ppu_req && $urandom_range(0, 99) < drop_pct) ppu_req = 1'b0;
    end
  endtask

  initial begin
    int ca, pa, cnt, acks, last_idle, n_idle;
    bit found;
    bit busyv[$];

    repeat (3) tick();
    chk("rst_addr", sd_addr, 20'h0);
    chk("rst_din", sd_din, 16'h0);
    chk("rst_ds", sd_ds, 2'b00);
    chk("rst_cpu_dout", cpu_dout, 16'h0);
    chk("rst_ppu_dout", ppu_dout, 16'h0);
    reset_n = 1'b1;

    // Tie right after reset: CPU first, PPU one slot later.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00ABC; cpu_ds = 2'b11;
    ppu_req = 1; ppu_we = 0; ppu_addr = 20'h54321; ppu_ds = 2'b11;
    ca = -1; pa = -1;
    for (int i = 0; i < 60 && (ca < 0 || pa < 0); i++) begin
      tick();
      if (cpu_ack && ca < 0) ca = i;
      if (ppu_ack && pa < 0) pa = i;
    end
    chk("tie_cpu_acked", ca >= 0, 1);
    chk("tie_ppu_acked", pa >= 0, 1);
    chk("tie_gap", 32'(pa - ca), 32'd8);

    // CPU read of the reference address.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h12345; cpu_ds = 2'b11;
    cnt = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (cpu_ack) found = 1;
      else if (sd_oe && !sd_we && sd_addr == 20'h12345) cnt++;
    end
    chk("rd_acked", found, 1);
    chk("rd_slot_len", cnt, 8);
    chk("rd_data", cpu_dout, 16'hBEEF);

    // PPU write leaves ppu_dout at its last read value.
    ppu_req = 1; ppu_we = 1; ppu_addr = 20'h0F0F0; ppu_din = 16'hA55A; ppu_ds = 2'b01;
    cnt = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (ppu_ack) found = 1;
      else if (sd_we && !sd_oe && sd_ds == 2'b01 && sd_din == 16'hA55A) cnt++;
    end
    chk("wr_acked", found, 1);
    chk("wr_slot_len", cnt, 8);
    chk("wr_dout_kept", ppu_dout, mem_data(20'h54321));

    // Request withdrawn before the slot boundary.
    for (int i = 0; i < 8 && m_phase != 1; i++) tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h33333;
    for (int i = 0; i < 8 && m_phase != 5; i++) tick();
    cpu_req = 0;
    acks = 0; cnt = 0;
    repeat (20) begin
      tick();
      if (cpu_ack) acks++;
      if (sd_oe || sd_we) cnt++;
    end
    chk("drop_no_ack", acks, 0);
    chk("drop_no_grant", cnt, 0);

    // Reset in phase 3 of a granted read.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h77777;
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      tick();
      if (m_infl && m_own == 0 && m_phase == 3) found = 1;
    end
    chk("mid_reset_reached", found, 1);
    reset_n = 0; cpu_req = 0;
    tick(); tick();
    reset_n = 1;
    chk("rel_sync_low", sd_sync, 1'b0);
    tick();
    chk("rel_sync_rise", sd_sync, 1'b1);
    acks = 0;
    repeat (20) begin
      tick();
      if (cpu_ack) acks++;
    end
    chk("reset_no_ack", acks, 0);

    // Both ports saturating: idle slot after every REF grants.
    rand_en = 1; raise_pct = 100; drop_pct = 0;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (m_phase == 0 && (sd_oe || sd_we)) found = 1;
    end
    chk("cont_start", found, 1);
    busyv.push_back(1);
    for (int i = 0; i < 400 && busyv.size() < 45; i++) begin
      tick();
      if (m_phase == 0) busyv.push_back(sd_oe | sd_we);
    end
    last_idle = -1; n_idle = 0;
    foreach (busyv[k]) begin
      if (!busyv[k]) begin
        n_idle++;
        if (last_idle >= 0) chk("refresh_gap", 32'(k - last_idle), REF + 1);
        else chk("first_run", 32'(k), REF);
        last_idle = k;
      end
    end
    chk("refresh_count", n_idle >= 2, 1);

    // Mixed random traffic with withdrawals.
    raise_pct = 30; drop_pct = 5;
    repeat (2000) tick();

    rand_en = 0; cpu_req = 0; ppu_req = 0;
    repeat (40) tick();
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("ppu_q_drained", ppu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
